// File: rtl/mem_stage.sv
// mem_stage -- Y86-64 memory stage with a request/acknowledge data-memory port.
//
// A one-cycle start pulse hands over icode/valE/valA/valP from execute. The
// instruction is decoded into read, write or no-access. Accesses whose 8-byte
// window would run past the end of memory are refused with stat=ADR. Legal
// accesses raise dmem_req until dmem_ack or until TIMEOUT request cycles have
// passed. Every accepted start ends in a one-cycle done pulse. A non-AOK
// status is sticky and blocks further starts until reset.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle pulse: icode/valE/valA/valP valid
//   icode             instruction code
//   valE, valA, valP  execute result, register A value, next PC
//   dmem_req/we       memory request and write enable
//   dmem_addr/wdata   memory address and write data
//   dmem_ack          memory completion strobe
//   dmem_rdata        read data, valid with dmem_ack
//   dmem_err          memory error, valid with dmem_ack
//   valM              last value read from memory
//   stat              1=AOK 2=HLT 3=ADR 4=INS
//   busy              high while not idle
//   done              one-cycle completion pulse
module mem_stage #(
  parameter logic [63:0] MEM_SIZE = 64'd8192,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_err,
  output logic [63:0] valM,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [63:0]        addr_q, addr_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [63:0]        valm_q, valm_d;
  logic [2:0]         stat_q, stat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               dec_access;
  logic               dec_we;
  logic [63:0]        dec_addr;
  logic [63:0]        dec_wdata;
  logic [2:0]         dec_stat;
  logic               dec_addr_ok;

  // Instruction decode: access kind, operands, and status for no-access codes.
  always_comb begin
    dec_access = 1'b0;
    dec_we     = 1'b0;
    dec_addr   = valE;
    dec_wdata  = valA;
    dec_stat   = STAT_AOK;
    case (icode)
      4'h4: begin dec_access = 1'b1; dec_we = 1'b1; dec_addr = valE; dec_wdata = valA; end
      4'h5: begin dec_access = 1'b1; dec_addr = valE; end
      4'h8: begin dec_access = 1'b1; dec_we = 1'b1; dec_addr = valE; dec_wdata = valP; end
      4'h9: begin dec_access = 1'b1; dec_addr = valA; end
      4'hA: begin dec_access = 1'b1; dec_we = 1'b1; dec_addr = valE; dec_wdata = valA; end
      4'hB: begin dec_access = 1'b1; dec_addr = valA; end
      4'h0: dec_stat = STAT_HLT;
      4'h1, 4'h2, 4'h3, 4'h6, 4'h7: dec_stat = STAT_AOK;
      default: dec_stat = STAT_INS;
    endcase
    // The whole 8-byte word must fit below MEM_SIZE.
    dec_addr_ok = (dec_addr <= (MEM_SIZE - 64'd8));
  end

  // Next-state logic for the IDLE/REQ/DONE controller and its outputs.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valm_d  = valm_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A non-AOK status locks out new work until reset.
        if (start && (stat_q == STAT_AOK)) begin
          if (dec_access && dec_addr_ok) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = dec_we;
            addr_d  = dec_addr;
            wdata_d = dec_wdata;
            cnt_d   = '0;
          end else if (dec_access) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            stat_d  = dec_stat;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (dmem_err) begin
            stat_d = STAT_ADR;
          end else if (!we_q) begin
            valm_d = dmem_rdata;
          end else begin
            valm_d = valm_q;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          stat_d  = STAT_ADR;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      valm_q  <= 64'd0;
      stat_q  <= STAT_AOK;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign valM       = valm_q;
  assign stat       = stat_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage: directed scenarios then
// randomized instructions against a behavioural model of the memory stage.
module tb_mem_stage;

  localparam logic [63:0] MEM_SIZE = 64'd8192;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic [63:0] valE = 64'd0;
  logic [63:0] valA = 64'd0;
  logic [63:0] valP = 64'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [63:0] dmem_rdata = 64'd0;
  logic        dmem_err = 1'b0;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Model state.
  logic [2:0]  m_stat = 3'd1;
  logic [63:0] m_valm = 64'd0;

  mem_stage #(.MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_err(dmem_err), .valM(valM), .stat(stat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural view of the instruction set: kind 0=none, 1=read, 2=write.
  function automatic void model_op(input logic [3:0] ic, input logic [63:0] e, a, p,
                                   output int kind, output logic [63:0] addr,
                                   output logic [63:0] wdata, output logic [2:0] st);
    kind = 0; addr = 64'd0; wdata = 64'd0; st = 3'd1;
    if (ic == 4'h4 || ic == 4'hA) begin kind = 2; addr = e; wdata = a; end
    else if (ic == 4'h8)          begin kind = 2; addr = e; wdata = p; end
    else if (ic == 4'h5)          begin kind = 1; addr = e; end
    else if (ic == 4'h9 || ic == 4'hB) begin kind = 1; addr = a; end
    else if (ic == 4'h0)          st = 3'd2;
    else if (ic >= 4'hC)          st = 3'd4;
    else                          st = 3'd1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_stat = 3'd1;
    m_valm = 64'd0;
    check("rst_req", {63'd0, dmem_req}, 64'd0);
    check("rst_we", {63'd0, dmem_we}, 64'd0);
    check("rst_addr", dmem_addr, 64'd0);
    check("rst_wdata", dmem_wdata, 64'd0);
    check("rst_valM", valM, 64'd0);
    check("rst_stat", {61'd0, stat}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
  endtask

  // Issue one instruction; ack_k=0 means the memory never answers.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] e, a, p,
                        input int ack_k, input bit err, input logic [63:0] rd, input bit poke);
    int kind;
    logic [63:0] x_addr, x_wdata;
    logic [2:0] x_st;
    bit ignored, issue;
    int x_req_cycles, x_done_cyc;
    int req_cycles, done_cyc, ndone;

    model_op(ic, e, a, p, kind, x_addr, x_wdata, x_st);
    ignored = (m_stat != 3'd1);
    issue = 1'b0;
    x_req_cycles = 0;
    x_done_cyc = -1;
    if (!ignored) begin
      if (kind == 0) begin
        m_stat = x_st; x_done_cyc = 1;
      end else if (x_addr > MEM_SIZE - 64'd8) begin
        m_stat = 3'd3; x_done_cyc = 1;
      end else begin
        issue = 1'b1;
        if (ack_k >= 1 && ack_k <= TIMEOUT) begin
          x_req_cycles = ack_k; x_done_cyc = ack_k + 1;
          if (err) m_stat = 3'd3;
          else if (kind == 1) m_valm = rd;
        end else begin
          x_req_cycles = TIMEOUT; x_done_cyc = TIMEOUT + 1;
          m_stat = 3'd3;
        end
      end
    end

    @(negedge clk);
    start = 1'b1; icode = ic; valE = e; valA = a; valP = p;
    @(negedge clk);
    start = 1'b0;
    check("busy_c1", {63'd0, busy}, {63'd0, !ignored});
    check("req_c1", {63'd0, dmem_req}, {63'd0, issue});
    if (issue) begin
      check("we", {63'd0, dmem_we}, {63'd0, kind == 2});
      if (kind == 2) check("wdata", dmem_wdata, x_wdata);
    end
    if (poke) begin
      // Start while busy must have no effect.
      start = 1'b1; icode = 4'h0; valE = MEM_SIZE;
    end
    req_cycles = 0; done_cyc = -1; ndone = 0;
    for (int cyc = 1; cyc <= TIMEOUT + 4; cyc++) begin
      if (cyc > 1) begin
        @(negedge clk);
        dmem_ack = 1'b0; dmem_err = 1'b0; start = 1'b0;
      end
      if (dmem_req) begin
        req_cycles++;
        check("addr", dmem_addr, x_addr);
        if (req_cycles == ack_k) begin
          dmem_ack = 1'b1; dmem_err = err; dmem_rdata = rd;
        end
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    check("req_cycles", 64'(req_cycles), 64'(x_req_cycles));
    check("done_count", 64'(ndone), (x_done_cyc < 0) ? 64'd0 : 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(x_done_cyc));
    check("stat", {61'd0, stat}, {61'd0, m_stat});
    check("valM", valM, m_valm);
    check("busy_end", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [3:0] ic;
    logic [63:0] e, a, p, rd;
    int k;
    bit err;
    logic [3:0] legal [11];
    legal = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

    repeat (2) @(negedge clk);
    do_reset();

    // mrmovq read acked on 2nd cycle.
    run_op(4'h5, 64'h100, 64'd0, 64'd0, 2, 1'b0, 64'hDEADBEEF, 1'b1);
    // pushq write with immediate ack; valM keeps the previous read.
    run_op(4'hA, 64'h1F8, 64'h55, 64'd0, 1, 1'b0, 64'h1234, 1'b0);
    // rmmovq past the end of memory, then an ignored start.
    run_op(4'h4, MEM_SIZE - 64'd4, 64'h77, 64'd0, 1, 1'b0, 64'd0, 1'b0);
    run_op(4'h5, 64'h100, 64'd0, 64'd0, 1, 1'b0, 64'h99, 1'b0);
    do_reset();
    // Boundary: last legal word address, call writes valP.
    run_op(4'h8, MEM_SIZE - 64'd8, 64'd0, 64'hABC, TIMEOUT, 1'b0, 64'd0, 1'b0);
    // ret with no ack: timeout.
    run_op(4'h9, 64'd0, 64'h40, 64'd0, 0, 1'b0, 64'd0, 1'b0);
    do_reset();
    // popq with memory error.
    run_op(4'hB, 64'd0, 64'h80, 64'd0, 3, 1'b1, 64'hBAD, 1'b0);
    do_reset();
    run_op(4'h0, 64'd0, 64'd0, 64'd0, 0, 1'b0, 64'd0, 1'b0);
    do_reset();
    run_op(4'hE, 64'd0, 64'd0, 64'd0, 0, 1'b0, 64'd0, 1'b0);
    do_reset();

    // Reset during REQ, then a late ack must be ignored.
    @(negedge clk);
    start = 1'b1; icode = 4'h5; valE = 64'h200;
    @(negedge clk);
    start = 1'b0;
    check("rstreq_req", {63'd0, dmem_req}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 64'hFEED;
    check("rstreq_req_low", {63'd0, dmem_req}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      check("rstreq_done", {63'd0, done}, 64'd0);
    end
    check("rstreq_valM", valM, 64'd0);
    check("rstreq_stat", {61'd0, stat}, 64'd1);
    m_stat = 3'd1; m_valm = 64'd0;

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) ic = 4'($urandom_range(0, 15));
      else ic = legal[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) e = MEM_SIZE - 64'd8 + 64'($urandom_range(1, 100));
      else e = {51'd0, 10'($urandom_range(0, 1023)), 3'd0};
      if ($urandom_range(0, 7) == 0) a = MEM_SIZE - 64'd8 + 64'($urandom_range(1, 100));
      else a = {51'd0, 10'($urandom_range(0, 1023)), 3'd0};
      p = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      err = ($urandom_range(0, 7) == 0);
      run_op(ic, e, a, p, k, err, rd, $urandom_range(0, 3) == 0);
      if (m_stat != 3'd1) begin
        run_op(4'h5, 64'h10, 64'd0, 64'd0, 1, 1'b0, 64'h5, 1'b0);
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_SIZE, default 64'd8192, SHALL be the data-memory size in bytes.
REQ-002 Parameter TIMEOUT, default 16, SHALL be the maximum number of request cycles before an access is aborted.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  SHALL be a one-cycle pulse marking icode/valE/valA/valP valid from execute.
REQ-006 icode  input  4  SHALL be the Y86-64 instruction code.
REQ-007 valE, valA, valP  input  64 each  SHALL be the execute result, register A value and next PC.
REQ-008 dmem_req  output  1  SHALL be the memory request, held until acknowledged or aborted.
REQ-009 dmem_we  output  1  SHALL be the write enable, valid while dmem_req is high.
REQ-010 dmem_addr, dmem_wdata  output  64 each  SHALL be the address and write data, stable while dmem_req is high.
REQ-011 dmem_ack  input  1  SHALL be the memory completion strobe.
REQ-012 dmem_rdata  input  64  SHALL be the read data, valid with dmem_ack.
REQ-013 dmem_err  input  1  SHALL be the memory error flag, valid with dmem_ack.
REQ-014 valM  output  64  SHALL be the last value read from memory.
REQ-015 stat  output  3  SHALL be the status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-016 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-017 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-019 Accesses SHALL be: rmmovq(4) write valA@valE; mrmovq(5) read @valE; call(8) write valP@valE; ret(9) read @valA; pushq(A) write valA@valE; popq(B) read @valA.
REQ-020 icode 1, 2, 3, 6, 7 SHALL perform no access and complete with stat unchanged (AOK).
REQ-021 icode 0 SHALL perform no access and set stat=HLT.
REQ-022 icode C-F SHALL perform no access and set stat=INS.
REQ-023 An access address greater than MEM_SIZE-8 (unsigned) SHALL NOT be issued and SHALL set stat=ADR.
REQ-024 IDLE + start + valid in-range access SHALL latch addr/we/wdata and go to REQ.
REQ-025 IDLE + start otherwise SHALL go to DONE.
REQ-026 REQ SHALL drive dmem_req=1 and count cycles.
REQ-027 In REQ, dmem_ack=1 SHALL transition to DONE; on reads valM<=dmem_rdata; if dmem_err=1, stat<=ADR and valM is unchanged.
REQ-028 In REQ, TIMEOUT cycles without dmem_ack SHALL drop dmem_req, set stat=ADR and go to DONE.
REQ-029 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-030 Latency: a start sampled at edge N with no access SHALL give done high in cycle N+1; an access acked on its k-th request cycle SHALL give done in cycle N+1+k (minimum N+2).
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 dmem_ack outside REQ SHALL be ignored.
REQ-033 A non-AOK stat SHALL be sticky: subsequent start pulses are ignored (busy stays 0, no done) until reset.
REQ-034 valM SHALL be unchanged by writes and no-access instructions.
REQ-035 dmem_req SHALL deassert in the cycle after the ack edge; there SHALL be no back-to-back requests without an intervening DONE.

Reset
REQ-036 rst_n=0 at an edge SHALL force IDLE and set dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, valM=0, stat=AOK (1), busy=0, done=0, timeout counter=0.
REQ-037 Reset in REQ or DONE SHALL abort the access; dmem_req is low the cycle after, and no done is produced.

Verification
REQ-038 mrmovq, valE=0x100, ack on 2nd request cycle with rdata=0xDEADBEEF -> dmem_we=0, dmem_addr=0x100, valM=0xDEADBEEF, done in N+3, stat=1.
REQ-039 pushq, valE=0x1F8, valA=0x55, immediate ack -> dmem_we=1, wdata=0x55, done in N+2, valM unchanged.
REQ-040 rmmovq, valE=MEM_SIZE-4 -> no dmem_req, done in N+1, stat=3; a later start is ignored.
REQ-041 ret, valA=0x40, ack never arrives -> dmem_req high for 16 cycles then low, stat=3, one done pulse.
REQ-042 icode=0 -> stat=2, done in N+1; icode=0xE (after reset) -> stat=4.
REQ-043 rst_n low during REQ, then ack arrives -> dmem_req low, valM=0, no done, stat=1.
